// File: rtl/sw_in_pkg.sv
// ============================================================================
// Module  : sw_in_pkg
// Brief   : Shared state enum and default constants for switch-input logic.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sw_in_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } sw_db_state_t;

    localparam int SW_WIDTH           = 8;
    localparam int SW_SYNC_STAGES     = 2;
    localparam int SW_DEBOUNCE_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/sw_debounce_sync_chain.sv
// ============================================================================
// Module  : sync_chain
// Brief   : WIDTH x STAGES flop chain with synchronous reset for async inputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_chain
    import sw_in_pkg::*;
#(
    parameter int WIDTH  = SW_WIDTH,
    parameter int STAGES = SW_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module  : sw_debounce
// Brief   : Synchronise and whole-vector debounce the slide switches; strobe
//           each committed change. Pending flag built when
//           SW_DEBOUNCE_VALID_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sw_debounce
    import sw_in_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_stb,
    output logic             sw_valid
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_w;

    sw_db_state_t     state_q, state_d;
    logic [WIDTH-1:0] cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             stb_q,   stb_d;
    logic             commit_w;
    logic             change_w;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sw_raw),
        .q_o   (sync_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
        end
    end

    // Any differing bit restarts the window for the whole vector.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_w != cand_q) begin
                    cand_d  = sync_w;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_w != cand_q) begin
                    cand_d = sync_w;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit_w = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A glitch that settles back to the current output commits silently.
    always_comb begin
        change_w = commit_w && (cand_q != out_q);
        out_d    = change_w ? cand_q : out_q;
        stb_d    = change_w;
    end

    assign sw_out = out_q;
    assign sw_stb = stb_q;

`ifdef SW_DEBOUNCE_VALID_EN
    logic valid_q, valid_d;

    // Set has priority over a simultaneous acknowledge.
    always_comb begin
        valid_d = valid_q;
        if (change_w) begin
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign sw_valid = valid_q;
`else
    logic w_unused_ack;
    assign w_unused_ack = ack;
    assign sw_valid     = 1'b0;
`endif

endmodule

`default_nettype wire
